// File: rtl/iter_shift_ctrl_pkg.sv
// rtl/iter_shift_ctrl_pkg.sv - shared types and widths for the iterative shift sequencer
package shift_pkg;

  localparam int DATA_W_C  = 32;
  localparam int SHAMT_W_C = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_RSV = 2'b01,
    SH_SRL = 2'b10,
    SH_SRA = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } shift_state_t;

endpackage

// File: rtl/iter_shift_ctrl_shift_step.sv
// rtl/iter_shift_ctrl_shift_step.sv - one combinational shift step of 1 or 4 positions
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_C
) (
  input  logic [DATA_W-1:0] data_i,
  input  shift_op_t         op_i,
  input  logic [2:0]        step_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      SH_SLL:  data_o = data_i << step_i;
      SH_SRL:  data_o = data_i >> step_i;
      SH_SRA:  data_o = DATA_W'($signed(data_i) >>> step_i);
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/iter_shift_ctrl.sv
// rtl/iter_shift_ctrl.sv - multi-cycle SLL/SRL/SRA sequencer with pipeline stall
// Optional ITER_SHIFT_FAST4_EN: shift 4 positions per cycle while at least 4 remain.
module iter_shift_ctrl
  import shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_C,
  parameter int SHAMT_W = SHAMT_W_C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               kill,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  result
);

  shift_state_t       state_q, state_d;
  shift_op_t          op_q, op_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2:0]         step;
  logic [DATA_W-1:0]  step_data;

`ifdef ITER_SHIFT_FAST4_EN
  assign step = (cnt_q >= SHAMT_W'(4)) ? 3'd4 : 3'd1;
`else
  assign step = 3'd1;
`endif

  shift_step #(.DATA_W(DATA_W)) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .step_i (step),
    .data_o (step_data)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start && !kill) begin
          op_d   = shift_op_t'(op);
          data_d = operand;
          cnt_d  = shamt;
          if (shamt == '0) begin
            state_d  = ST_DONE;
            result_d = operand;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        // A flush leaves result untouched so the last completed value stays visible.
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          data_d = step_data;
          cnt_d  = cnt_q - SHAMT_W'(step);
          if (cnt_q == SHAMT_W'(step)) begin
            state_d  = ST_DONE;
            result_d = step_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= SH_SLL;
      data_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
